// File: rtl/led_pkg.sv
// Shared constants and sizing helper for the LED PWM driver.
// No logic, no latency, no flow control.
package led_pkg;

    localparam int          PWM_BITS_DEF = 8;
    localparam logic [31:0] DUTY_OFF     = '0;
    localparam logic [31:0] DUTY_FULL    = '1;

    // Width of a counter that must hold 0..modulus-1, never less than one bit.
    function automatic int cnt_w(input int modulus);
        return (modulus <= 2) ? 1 : $clog2(modulus);
    endfunction

endpackage

// File: rtl/led_pwm_timebase.sv
// Prescaler plus PWM counter; tick/boundary are combinational from the counter registers.
// Free-running, no backpressure: counts every clk, restarts from zero on reset.
module led_pwm_timebase
    import led_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEF,
    parameter int PRESCALE = 50
) (
    input  logic                clk,
    input  logic                reset,
    output logic                tick_o,
    output logic [PWM_BITS-1:0] pwm_cnt_o,
    output logic                boundary_o
);

    localparam int                  PRE_W    = cnt_w(PRESCALE);
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] PWM_LAST = {PWM_BITS{1'b1}};

    logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                tick;

    always_comb begin
        tick      = (pre_cnt_q == PRE_LAST);
        pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
        pwm_cnt_d = pwm_cnt_q;
        if (tick) begin
            pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt_q <= '0;
            pwm_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    assign tick_o     = tick;
    assign pwm_cnt_o  = pwm_cnt_q;
    assign boundary_o = tick && (pwm_cnt_q == PWM_LAST);

endmodule

// File: rtl/led_pwm_driver.sv
// Brightness PWM (+ per-LED blink under LED_BLINK_EN) on the PIO pattern; inputs shadowed at period boundaries.
// led_out is registered, 1 clk behind counters/shadows; no backpressure, inputs are sampled, never stalled.
module led_pwm_driver
    import led_pkg::*;
#(
    parameter int NUM_LEDS   = 8,
    parameter int PWM_BITS   = PWM_BITS_DEF,
    parameter int PRESCALE   = 50,
    parameter int BLINK_HALF = 1953
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_LEDS-1:0] pattern_in,
    input  logic [PWM_BITS-1:0] duty,
    input  logic [NUM_LEDS-1:0] blink_mask,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                period_start,
    output logic [NUM_LEDS-1:0] pattern_q
);

    localparam logic [PWM_BITS-1:0] FULL = DUTY_FULL[PWM_BITS-1:0];
    localparam logic [PWM_BITS-1:0] OFF  = DUTY_OFF[PWM_BITS-1:0];

    logic                tick_unused;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                boundary;

    led_pwm_timebase #(
        .PWM_BITS (PWM_BITS),
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .clk        (clk),
        .reset      (reset),
        .tick_o     (tick_unused),
        .pwm_cnt_o  (pwm_cnt),
        .boundary_o (boundary)
    );

    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [NUM_LEDS-1:0] pattern_sh_q, pattern_sh_d;
    logic [NUM_LEDS-1:0] led_q, led_d;
    logic [NUM_LEDS-1:0] blank;
    logic                bnd_q, period_start_q;
    logic                on;

`ifdef LED_BLINK_EN
    localparam int               BLINK_W    = cnt_w(BLINK_HALF);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    logic [NUM_LEDS-1:0] mask_q, mask_d;
    logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic                blink_phase_q, blink_phase_d;

    // Phase flips on the same boundary edge that loads the new shadows.
    always_comb begin
        mask_d        = mask_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (boundary) begin
            mask_d = blink_mask;
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q        <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            mask_q        <= mask_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign blank = mask_q & {NUM_LEDS{blink_phase_q}};
`else
    logic unused_blink;
    assign unused_blink = (^blink_mask) ^ (BLINK_HALF < 1);
    assign blank        = '0;
`endif

    assign on = (duty_q == FULL) | (pwm_cnt < duty_q);

    always_comb begin
        duty_d       = duty_q;
        pattern_sh_d = pattern_sh_q;
        if (boundary) begin
            duty_d       = duty;
            pattern_sh_d = pattern_in;
        end
        led_d = pattern_sh_q & {NUM_LEDS{on}} & ~blank;
    end

    // bnd_q marks the first pwm_cnt==0 cycle; period_start follows it one clk later, aligned with led_out.
    always_ff @(posedge clk) begin
        if (reset) begin
            duty_q         <= OFF;
            pattern_sh_q   <= '0;
            led_q          <= '0;
            bnd_q          <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            duty_q         <= duty_d;
            pattern_sh_q   <= pattern_sh_d;
            led_q          <= led_d;
            bnd_q          <= boundary;
            period_start_q <= bnd_q;
        end
    end

    assign led_out      = led_q;
    assign period_start = period_start_q;
    assign pattern_q    = pattern_sh_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Directed bench for led_pwm_driver with PWM_BITS=4, PRESCALE=2, BLINK_HALF=2 (32 clk per period).
module tb_led_pwm_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] pattern_in;
    logic [3:0] duty;
    logic [7:0] blink_mask;
    logic [7:0] led_out;
    logic       period_start;
    logic [7:0] pattern_q;

    int pe = 0;
    int rel = 0;
    int n_run = 0;
    int n_fail = 0;

    led_pwm_driver #(
        .NUM_LEDS   (8),
        .PWM_BITS   (4),
        .PRESCALE   (2),
        .BLINK_HALF (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pattern_in   (pattern_in),
        .duty         (duty),
        .blink_mask   (blink_mask),
        .led_out      (led_out),
        .period_start (period_start),
        .pattern_q    (pattern_q)
    );

    always #5 clk = ~clk;
    always @(posedge clk) pe++;

    // Steps at least one cycle, then stops on the next period_start negedge.
    task automatic wait_ps();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 80 && !got; i++) begin
            @(negedge clk);
            if (period_start === 1'b1) got = 1'b1;
        end
        n_run++;
        if (!got) begin
            n_fail++;
            $display("FAIL wait_ps: period_start seen=0, required=1 within 80 clk");
        end
    endtask

    task automatic test_reset();
        logic [7:0] exp_led;
        reset      = 1'b1;
        pattern_in = 8'hFF;
        duty       = 4'hF;
        blink_mask = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_run++;
            if (led_out !== 8'h00 || period_start !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: led=%h ps=%b, required led=00 ps=0", i, led_out, period_start);
            end
        end
        reset = 1'b0;
        rel   = pe;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            exp_led = (k >= 33) ? 8'hFF : 8'h00;
            n_run++;
            if (led_out !== exp_led) begin
                n_fail++;
                $display("FAIL reset_led[k=%0d]: led=%h, required %h", k, led_out, exp_led);
            end
            n_run++;
            if (period_start !== (k == 33)) begin
                n_fail++;
                $display("FAIL reset_ps[k=%0d]: ps=%b, required %b", k, period_start, (k == 33));
            end
        end
    endtask

    task automatic test_pwm_half();
        logic [7:0] exp_led;
        wait_ps();
        duty       = 4'h8;
        pattern_in = 8'hA5;
        wait_ps();
        for (int j = 0; j < 64; j++) begin
            exp_led = ((j % 32) < 16) ? 8'hA5 : 8'h00;
            n_run++;
            if (led_out !== exp_led) begin
                n_fail++;
                $display("FAIL pwm_half_led[j=%0d]: led=%h, required %h", j, led_out, exp_led);
            end
            n_run++;
            if (period_start !== ((j % 32) == 0)) begin
                n_fail++;
                $display("FAIL pwm_half_ps[j=%0d]: ps=%b, required %b", j, period_start, ((j % 32) == 0));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_duty_edges();
        duty = 4'h0;
        wait_ps();
        for (int j = 0; j < 32; j++) begin
            n_run++;
            if (led_out !== 8'h00) begin
                n_fail++;
                $display("FAIL duty_zero[j=%0d]: led=%h, required 00", j, led_out);
            end
            @(negedge clk);
        end
        duty = 4'hF;
        wait_ps();
        for (int j = 0; j < 32; j++) begin
            n_run++;
            if (led_out !== 8'hA5) begin
                n_fail++;
                $display("FAIL duty_full[j=%0d]: led=%h, required A5", j, led_out);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mid_change();
        logic [7:0] exp_led;
        for (int j = 0; j <= 32; j++) begin
            if (j == 16) pattern_in = 8'h3C;
            exp_led = (j < 32) ? 8'hA5 : 8'h3C;
            n_run++;
            if (led_out !== exp_led) begin
                n_fail++;
                $display("FAIL mid_led[j=%0d]: led=%h, required %h", j, led_out, exp_led);
            end
            if (j == 30) begin
                n_run++;
                if (pattern_q !== 8'hA5) begin
                    n_fail++;
                    $display("FAIL mid_shadow_old: pattern_q=%h, required A5", pattern_q);
                end
            end
            if (j == 31) begin
                n_run++;
                if (pattern_q !== 8'h3C) begin
                    n_fail++;
                    $display("FAIL mid_shadow_new: pattern_q=%h, required 3C", pattern_q);
                end
            end
            if (j == 32) begin
                n_run++;
                if (period_start !== 1'b1) begin
                    n_fail++;
                    $display("FAIL mid_ps: ps=%b, required 1", period_start);
                end
            end
            if (j < 32) @(negedge clk);
        end
    endtask

    task automatic test_blink();
        logic [7:0] exp_led;
        int         k;
        int         m;
        pattern_in = 8'hFF;
        blink_mask = 8'h0F;
        duty       = 4'hF;
        wait_ps();
        for (int p = 0; p < 4; p++) begin
            k = pe - rel;
            m = (k - 33) / 32;
`ifdef LED_BLINK_EN
            // Phase after boundary m: 0,1,1,0,0,1,... (two periods per half-cycle)
            exp_led = (((m + 1) / 2) % 2 == 1) ? 8'hF0 : 8'hFF;
`else
            exp_led = (m >= 0) ? 8'hFF : 8'hFF;
`endif
            for (int j = 0; j < 32; j++) begin
                n_run++;
                if (led_out !== exp_led) begin
                    n_fail++;
                    $display("FAIL blink[m=%0d j=%0d]: led=%h, required %h", m, j, led_out, exp_led);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_led;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_run++;
        if (led_out !== 8'h00 || period_start !== 1'b0 || pattern_q !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid: led=%h ps=%b pq=%h, required 00 0 00", led_out, period_start, pattern_q);
        end
        reset = 1'b0;
        rel   = pe;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            exp_led = (k >= 33) ? 8'hFF : 8'h00;
            n_run++;
            if (period_start !== (k == 33)) begin
                n_fail++;
                $display("FAIL reset_mid_ps[k=%0d]: ps=%b, required %b", k, period_start, (k == 33));
            end
            n_run++;
            if (led_out !== exp_led) begin
                n_fail++;
                $display("FAIL reset_mid_led[k=%0d]: led=%h, required %h", k, led_out, exp_led);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pwm_half();
        test_duty_edges();
        test_mid_change();
        test_blink();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
